// File: rtl/fwd_pkg.sv
// ============================================================================
// fwd_pkg : shared select encoding, scoreboard entry type and helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package fwd_pkg;

   localparam int SEL_IMM      = 0;
   localparam int SEL_REG      = 1;
   localparam int SEL_FWD_BASE = 2;

   // Register tag storage is sized for the widest supported REG_AW (<= 8).
   localparam int SB_RW_W = 8;

   typedef struct packed {
      logic               valid;
      logic [SB_RW_W-1:0] rw;
      logic               isLoad;
   } sb_entry_t;

   function automatic int sel_w(input int depth);
      return $clog2(depth + 2);
   endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_prio_match.sv
// ============================================================================
// fwd_prio_match : youngest-producer lookup of one source over the scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module fwd_prio_match
   import fwd_pkg::*;
#(
   parameter int DEPTH  = 3,
   parameter int REG_AW = 5,
   localparam int KW    = $clog2(DEPTH)
) (
   input  sb_entry_t [DEPTH-1:0] entries,
   input  logic [REG_AW-1:0]     src,
   output logic                  hit,
   output logic [KW-1:0]         k,
   output logic                  isLoad
);

   always_comb begin
      hit    = 1'b0;
      k      = '0;
      isLoad = 1'b0;
      // Scan oldest to youngest so the lowest stage index is written last.
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (entries[i].valid && (entries[i].rw == SB_RW_W'(src))) begin
            hit    = 1'b1;
            k      = KW'(i);
            isLoad = entries[i].isLoad;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/fwd_scoreboard_unit.sv
// ============================================================================
// fwd_scoreboard_unit : scoreboard-based operand forwarding and load-use stall
// Rev 1.0
// ============================================================================
`default_nettype none

module fwd_scoreboard_unit
   import fwd_pkg::*;
#(
   parameter int REG_AW     = 5,
   parameter int DEPTH      = 3,
   parameter int LOAD_READY = 1,
   parameter int CNT_W      = 16,
   localparam int SEL_W     = sel_w(DEPTH),
   localparam int KW        = $clog2(DEPTH)
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              Hold,
   input  logic              Flush,
   input  logic              ID_Valid,
   input  logic [REG_AW-1:0] ID_Rs,
   input  logic [REG_AW-1:0] ID_Rt,
   input  logic [REG_AW-1:0] ID_Rw,
   input  logic              ID_RegWrite,
   input  logic              ID_MemRead,
   input  logic              ID_MemWrite,
   input  logic              UseShamt,
   input  logic              UseImmed,
   output logic [SEL_W-1:0]  AluOpCtrlA,
   output logic [SEL_W-1:0]  AluOpCtrlB,
   output logic [SEL_W-1:0]  DataMemFwdSel,
   output logic              Stall,
   output logic [CNT_W-1:0]  StallCount
);

   sb_entry_t [DEPTH-1:0] r_sb;
   logic [CNT_W-1:0]      r_stallCount;
   sb_entry_t             w_newEntry;

   logic          w_hitA, w_hitB, w_hitD;
   logic [KW-1:0] w_kA, w_kB, w_kD;
   logic          w_ldA, w_ldB, w_ldD;
   logic          w_hazA, w_hazB;

   fwd_prio_match #(.DEPTH(DEPTH), .REG_AW(REG_AW)) u_matchA (
      .entries (r_sb),
      .src     (ID_Rs),
      .hit     (w_hitA),
      .k       (w_kA),
      .isLoad  (w_ldA)
   );

   fwd_prio_match #(.DEPTH(DEPTH), .REG_AW(REG_AW)) u_matchB (
      .entries (r_sb),
      .src     (ID_Rt),
      .hit     (w_hitB),
      .k       (w_kB),
      .isLoad  (w_ldB)
   );

   fwd_prio_match #(.DEPTH(DEPTH), .REG_AW(REG_AW)) u_matchD (
      .entries (r_sb),
      .src     (ID_Rt),
      .hit     (w_hitD),
      .k       (w_kD),
      .isLoad  (w_ldD)
   );

   always_comb begin
      AluOpCtrlA    = SEL_W'(SEL_REG);
      AluOpCtrlB    = SEL_W'(SEL_REG);
      DataMemFwdSel = SEL_W'(SEL_REG);

      if (UseShamt)    AluOpCtrlA = SEL_W'(SEL_IMM);
      else if (w_hitA) AluOpCtrlA = SEL_W'(SEL_FWD_BASE) + SEL_W'(w_kA);

      if (UseImmed)    AluOpCtrlB = SEL_W'(SEL_IMM);
      else if (w_hitB) AluOpCtrlB = SEL_W'(SEL_FWD_BASE) + SEL_W'(w_kB);

      if (w_hitD)      DataMemFwdSel = SEL_W'(SEL_FWD_BASE) + SEL_W'(w_kD);

      // A load is unusable until it reaches stage LOAD_READY.
      w_hazA = ID_Valid & ~UseShamt & w_hitA & w_ldA & (int'(w_kA) < LOAD_READY);
      w_hazB = (ID_Valid & ~UseImmed    & w_hitB & w_ldB & (int'(w_kB) < LOAD_READY))
             | (ID_Valid &  ID_MemWrite & w_hitD & w_ldD & (int'(w_kD) < LOAD_READY));
      Stall  = (w_hazA | w_hazB) & ~Flush;

      w_newEntry.valid  = ID_Valid & ID_RegWrite & (ID_Rw != '0) & ~Stall & ~Flush;
      w_newEntry.rw     = SB_RW_W'(ID_Rw);
      w_newEntry.isLoad = ID_MemRead;
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_sb         <= '0;
         r_stallCount <= '0;
      end else if (!Hold) begin
         r_sb <= {r_sb[DEPTH-2:0], w_newEntry};
         if (Stall && (r_stallCount != '1)) begin
            r_stallCount <= r_stallCount + CNT_W'(1);
         end
      end
   end

   assign StallCount = r_stallCount;

endmodule

`default_nettype wire

// File: doc/fwd_scoreboard_unit.md
Name: fwd_scoreboard_unit

Overview:
- Parametrised successor to the pipeline's combinational forwarding unit.
- Keeps its own registered scoreboard of in-flight destination registers across DEPTH post-ID stages; it no longer takes per-stage Rw/RegWrite ports.
- Per ID-stage instruction it produces ALU operand-A, operand-B and store-data forward selects, plus a load-use Stall with a saturating stall counter.
- Sits beside the ID/EX pipeline register and drives the operand muxes and the PC/IF-ID hold.

Parameters:
- REG_AW, 5, register address width.
- DEPTH, 3, tracked stages after ID (0 = EX, 1 = MEM, 2 = WB); legal range 2..6.
- LOAD_READY, 1, first stage index whose output carries load data; must be < DEPTH.
- CNT_W, 16, StallCount width.

Ports:
- CLK, input, 1, clock.
- Reset, input, 1, synchronous active-high reset.
- Hold, input, 1, external pipeline freeze (e.g. memory wait); scoreboard does not advance.
- Flush, input, 1, kill the ID instruction (branch taken); a bubble enters stage 0.
- ID_Valid, input, 1, ID holds a real instruction.
- ID_Rs, input, REG_AW, source A.
- ID_Rt, input, REG_AW, source B / store data.
- ID_Rw, input, REG_AW, destination.
- ID_RegWrite, input, 1, instruction writes ID_Rw.
- ID_MemRead, input, 1, instruction is a load.
- ID_MemWrite, input, 1, instruction is a store (Rt is needed as data).
- UseShamt, input, 1, operand A is shamt.
- UseImmed, input, 1, operand B is the immediate.
- AluOpCtrlA, output, SEL_W, operand-A select.
- AluOpCtrlB, output, SEL_W, operand-B select.
- DataMemFwdSel, output, SEL_W, store-data select.
- Stall, output, 1, load-use hazard; hold PC and IF/ID.
- StallCount, output, CNT_W, saturating count of stall cycles.

Behaviour:
- SEL_W = $clog2(DEPTH+2). Select encoding:
  - 0 = immediate/shamt.
  - 1 = register file.
  - 2+k = forward from the output of stage k.
- Scoreboard entry per stage: {valid, rw, is_load}. valid is set only when RegWrite=1 and Rw != 0, so $0 is never forwarded.
- Reset: all entry valid bits = 0 and StallCount = 0. Outputs then follow directly: AluOpCtrlA = UseShamt ? 0 : 1, AluOpCtrlB = UseImmed ? 0 : 1, DataMemFwdSel = 1, Stall = 0.
- Reset has priority over Hold and Flush.
- Advance rule, each clock with Reset=0 and Hold=0:
  - entry[k+1] <= entry[k] for k = 0..DEPTH-2; entry[DEPTH-1] is discarded.
  - entry[0] <= {ID_Valid & ID_RegWrite & (ID_Rw != 0) & ~Stall & ~Flush, ID_Rw, ID_MemRead}.
  - A stalled or flushed instruction therefore inserts a bubble.
- Hold=1: all entries and StallCount keep their values. Outputs are still evaluated combinationally.
- Match for source s (Rs or Rt): lowest k with entry[k].valid and entry[k].rw == s. The youngest producer wins; no match gives select 1.
- Operand A: UseShamt=1 gives 0, otherwise the match result.
- Operand B: UseImmed=1 gives 0, otherwise the match result.
- DataMemFwdSel: match result on Rt; the immediate mask is ignored.
- Need flags:
  - needA = ID_Valid & ~UseShamt.
  - needB = ID_Valid & (~UseImmed | ID_MemWrite).
- Load-use: Stall = 1 when a needed source's youngest match has is_load=1 and k < LOAD_READY. Flush=1 forces Stall = 0.
- Select outputs are don't-care while Stall=1; the bench must not check them.
- Latency: selects and Stall are combinational, zero cycles from the ID inputs. Scoreboard update takes 1 cycle.
- With default parameters, a load followed immediately by a dependent instruction gives exactly 1 stall cycle, then select 3 (MEM output).
- StallCount increments on every clock with Stall=1 & Hold=0 & Reset=0, and saturates at all-ones.
- Simultaneous Stall and Hold: no scoreboard shift, no count. Stall is re-evaluated after Hold deasserts.
- No internal state besides the scoreboard and the counter.

Decomposition:
- Shared package fwd_pkg:
  - SEL_IMM = 0, SEL_REG = 1, SEL_FWD_BASE = 2.
  - sb_entry_t struct {valid, rw, is_load}.
  - sel_w(DEPTH) function.
- Sub-module fwd_prio_match: a combinational priority matcher over the DEPTH entries for one source address. It returns {hit, k, is_load} and is instantiated three times (Rs, Rt for ALU, Rt for store).

Test Plan:
- Reset=1 for 2 cycles, then ADD $3,$1,$2 with no producers -> AluOpCtrlA = 1, AluOpCtrlB = 1, Stall = 0, StallCount = 0.
- ADD $5 followed by SUB $6,$5,$5 -> A = B = 2. Two cycles later with one bubble between -> A = B = 3. At distance 3 -> 4. At distance 4 -> 1.
- LW $7, then ADD $8,$7,$1 -> Stall = 1 for exactly 1 cycle and StallCount = 1. Next cycle A = 3 and Stall = 0.
- LW $7, then SW $7,0($2) (UseImmed = 1) -> Stall = 1, then DataMemFwdSel = 3 while AluOpCtrlB = 0.
- Two producers in flight (ADD $4 at stage 1, ADD $4 at stage 0), then OR $9,$4,$0 -> A = 2 (youngest wins) and B = 1 ($0 never forwarded, even with RegWrite to $0 in flight).
- Boundary cases:
  - Hold=1 for 3 cycles mid-hazard -> entries frozen, Stall stays 1, StallCount unchanged.
  - Flush during a stall -> Stall = 0 and a bubble is inserted.
  - Reset mid-sequence -> every select returns to 1 on the next cycle.
  - Preload StallCount to all-ones minus 1 and stall 3 cycles -> count saturates at all-ones.
